// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (cpu, dma), the memory block and
// mem_bus_arbiter. The master modport is the environment side (requesters and
// memory); the slave modport is the arbiter side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_ack;
    // DMA/IO requester
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_ack;
    // shared read return
    logic [DATA_W-1:0] rdata;
    // memory port
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_ack, dma_gnt, dma_ack,
        input  rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_ack, dma_gnt, dma_ack,
        output rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU (port 0) and the
// DMA/IO engine (port 1). One request is latched at a time, strobed for
// WAIT_CYCLES+1 cycles, then acknowledged for one cycle before the bus is
// released. Ties are broken round-robin; defining MEM_ARB_FIXED_PRIO_EN
// makes the CPU always win a tie instead.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1   // 0..7
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic              owner_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [2:0]        cnt_reg;

    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    logic [1:0]        ack_vec;
    logic              tie_owner;
    logic              sel_valid;
    logic              sel_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              owner_active;
    logic              ack_active;
    logic              mem_rd_next;
    logic              mem_wr_next;
    logic              last_beat;

    assign req_vec   = {bus.dma_req, bus.cpu_req};
    assign last_beat = (state_reg == ACCESS) && (cnt_reg == 3'd0);

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign tie_owner = 1'b0;
`else
    logic last_owner_reg;

    assign tie_owner = ~last_owner_reg;

    // Remember who finished the last access so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= 1'b1;
        end else if (last_beat) begin
            last_owner_reg <= owner_reg;
        end
    end
`endif

    // Operands of whichever requester is being selected this cycle.
    assign sel_we    = sel_owner ? bus.dma_we    : bus.cpu_we;
    assign sel_addr  = sel_owner ? bus.dma_addr  : bus.cpu_addr;
    assign sel_wdata = sel_owner ? bus.dma_wdata : bus.cpu_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, requester selection and strobe decode.
    always_comb begin
        state_next   = state_reg;
        sel_valid    = 1'b0;
        sel_owner    = 1'b0;
        owner_active = 1'b0;
        ack_active   = 1'b0;
        mem_rd_next  = 1'b0;
        mem_wr_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_vec != 2'b00) begin
                    sel_valid  = 1'b1;
                    sel_owner  = (req_vec == 2'b11) ? tie_owner : req_vec[1];
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                owner_active = 1'b1;
                mem_rd_next  = ~we_reg;
                mem_wr_next  = we_reg;
                if (cnt_reg == 3'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                owner_active = 1'b1;
                ack_active   = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the selected request, count wait states, capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            cnt_reg   <= 3'd0;
        end else if (sel_valid) begin
            owner_reg <= sel_owner;
            we_reg    <= sel_we;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_wdata;
            cnt_reg   <= WAIT_INIT;
        end else if (state_reg == ACCESS) begin
            if (cnt_reg == 3'd0) begin
                if (!we_reg) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end else begin
                cnt_reg <= cnt_reg - 3'd1;
            end
        end
    end

    // Per-port grant/ack decode from the single owner register.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi] = owner_active && (owner_reg == 1'(gi));
        assign ack_vec[gi] = ack_active   && (owner_reg == 1'(gi));
    end

    assign bus.cpu_gnt   = gnt_vec[0];
    assign bus.dma_gnt   = gnt_vec[1];
    assign bus.cpu_ack   = ack_vec[0];
    assign bus.dma_ack   = ack_vec[1];
    assign bus.rdata     = rdata_reg;
    assign bus.mem_rd    = mem_rd_next;
    assign bus.mem_wr    = mem_wr_next;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.busy      = (state_reg != IDLE);
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory port between two requesters: the CPU controller (port 0, "cpu") and a DMA/IO engine (port 1, "dma").
- Latches one request at a time and drives mem_rd/mem_wr/address/data for a fixed number of wait states.
- Returns read data and a one-cycle ack, then releases the bus.
- Sits between the controller/datapath address and data buses and the memory block.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, data width
WAIT_CYCLES, 1, extra memory wait states per access; legal range 0..7; each access strobes memory for WAIT_CYCLES+1 cycles

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU owns bus (ACCESS and DONE states)
cpu_ack  out  1  one-cycle completion pulse to CPU
dma_req  in  1  DMA access request, held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA owns bus
dma_ack  out  1  one-cycle completion pulse to DMA
rdata  out  DATA_W  registered read data, valid when an ack is high for a read
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, sampled on last strobe cycle
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at rising edge):
  - state=IDLE; all outputs 0, including rdata, mem_addr and mem_wdata.
  - last_owner=1 (DMA), so the CPU wins the first tie.
  - wait counter=0.
  - Reset mid-access aborts the transfer: no ack is issued and strobes drop in the cycle after the edge.
- Registered FSM with states IDLE, ACCESS, DONE.
- IDLE:
  - If neither req is high: stay in IDLE.
  - If exactly one req is high: select that requester.
  - If both are high: select the requester that is not last_owner (round-robin).
  - On selection: latch owner, we, addr and wdata into internal registers; load counter with WAIT_CYCLES; next state ACCESS.
- ACCESS:
  - Owner's gnt=1; mem_addr/mem_wdata come from the latched registers.
  - mem_rd=~we_l and mem_wr=we_l, held for WAIT_CYCLES+1 consecutive cycles.
  - Counter decrements each cycle. When counter==0: if read, rdata<=mem_rdata; last_owner<=owner; next state DONE.
- DONE:
  - Strobes low; owner's gnt stays 1; owner's ack=1 for exactly this cycle.
  - Both reqs are ignored in this cycle; next state IDLE.
- Handshake:
  - Requester drops req on the edge where it samples ack=1.
  - A req still high in the following IDLE cycle is a new transaction.
  - req or operands changing during ACCESS have no effect; operands are latched.
  - Dropping req before ack does not cancel the access; the ack is still issued.
- Latency (req high in IDLE at cycle 0):
  - gnt and strobe from cycle 1.
  - ack at cycle WAIT_CYCLES+2.
  - Next grant no earlier than cycle WAIT_CYCLES+4.
- Exclusivity: at most one of cpu_gnt/dma_gnt, at most one ack, and at most one of mem_rd/mem_wr are high in any cycle.
- rdata holds its value until the next read completes; writes leave rdata unchanged.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- When defined: fixed priority; the CPU always wins a tie in IDLE, and last_owner is unused (may be removed).
- When undefined: round-robin as described above.
- Timing, handshake and reset behaviour are identical in both builds.

Test Plan:
- WAIT_CYCLES=1; cpu read addr 0x3C, mem_rdata=0xA5 -> cpu_gnt cycles 1-3, mem_rd cycles 1-2 with mem_addr=0x3C, cpu_ack cycle 3 with rdata=0xA5, busy low cycle 4.
- dma write addr 0x10 data 0x7E -> mem_wr high 2 cycles with mem_wdata=0x7E; dma_ack one cycle; rdata unchanged; cpu_gnt never high.
- cpu_req and dma_req both held continuously after reset -> grants alternate cpu, dma, cpu, dma (round-robin). With MEM_ARB_FIXED_PRIO_EN -> cpu, cpu, ...; dma only after cpu_req drops.
- WAIT_CYCLES=0; back-to-back cpu reads of 0x01, 0x02 -> each strobe lasts 1 cycle; ack at cycle 2; second gnt at cycle 4; rdata updates per access.
- rst pulsed during ACCESS of a dma write -> next cycle mem_wr=0, dma_gnt=0, no dma_ack, state IDLE; first tie after reset goes to cpu.
- cpu_req dropped during ACCESS, cpu_addr changed mid-access -> access completes at the originally latched address; cpu_ack still pulses once.
